display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 4-digit BCD counter display (units, tens, hundreds, thousands).

---
 rtl/display_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit multiplexed display scan controller with tear-free load
// Shares one 7-segment decoder across four anodes and blanks leading zeros.
module display_scan_ctrl #(
  parameter int REFRESH_DIV   = 50000,
  parameter bit ANODE_ACT_LOW = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  output logic        ready,
  output logic [3:0]  dec_in,
  output logic [3:0]  anode,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int            PW        = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [3:0]    ANODE_OFF = ANODE_ACT_LOW ? 4'b1111 : 4'b0000;
  localparam logic [3:0]    ANODE_RST = ANODE_ACT_LOW ? 4'b1110 : 4'b0001;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_active;
  logic [15:0]   r_shadow;
  logic          r_pending;
  logic          r_ready;
  logic [3:0]    r_dec;
  logic [3:0]    r_anode;
  logic          r_frame_tick;

  logic          w_tick;
  logic          w_boundary;
  logic          w_commit;
  logic          w_accept;
  logic [PW-1:0] w_presc_nxt;
  logic [1:0]    w_idx_nxt;
  logic [15:0]   w_active_nxt;
  logic [3:0]    w_dec_nxt;
  logic          w_blank_nxt;
  logic [3:0]    w_onehot;
  logic [3:0]    w_anode_nxt;

  always_comb begin
    w_tick       = en && (r_presc == PRESC_MAX);
    w_boundary   = w_tick && (r_idx == 2'd3);
    w_commit     = w_boundary && r_pending;
    w_accept     = load && r_ready;
    w_presc_nxt  = r_presc;
    if (en) begin
      w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
    end
    w_idx_nxt    = w_tick ? r_idx + 2'd1 : r_idx;
    w_active_nxt = w_commit ? r_shadow : r_active;
  end

  // Outputs are computed from next-state values so they change on the same edge as digit_idx/active.
  always_comb begin
    w_dec_nxt   = w_active_nxt[3:0];
    w_blank_nxt = 1'b0;
    case (w_idx_nxt)
      2'd0: w_dec_nxt = w_active_nxt[3:0];
      2'd1: begin
        w_dec_nxt   = w_active_nxt[7:4];
        w_blank_nxt = (w_active_nxt[15:4] == 12'd0);
      end
      2'd2: begin
        w_dec_nxt   = w_active_nxt[11:8];
        w_blank_nxt = (w_active_nxt[15:8] == 8'd0);
      end
      default: begin
        w_dec_nxt   = w_active_nxt[15:12];
        w_blank_nxt = (w_active_nxt[15:12] == 4'd0);
      end
    endcase
    w_onehot    = 4'b0001 << w_idx_nxt;
    w_anode_nxt = ANODE_ACT_LOW ? ~w_onehot : w_onehot;
    if (!en || (BLANK_LEADING && w_blank_nxt)) begin
      w_anode_nxt = ANODE_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= 2'd0;
      r_active     <= 16'd0;
      r_shadow     <= 16'd0;
      r_pending    <= 1'b0;
      r_ready      <= 1'b1;
      r_dec        <= 4'd0;
      r_anode      <= ANODE_RST;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_idx        <= w_idx_nxt;
      r_active     <= w_active_nxt;
      r_dec        <= w_dec_nxt;
      r_anode      <= w_anode_nxt;
      r_frame_tick <= w_boundary;
      // ready is low exactly while pending, so accept and commit never coincide.
      if (w_accept) begin
        r_shadow  <= digits_in;
        r_pending <= 1'b1;
        r_ready   <= 1'b0;
      end else if (w_commit) begin
        r_pending <= 1'b0;
        r_ready   <= 1'b1;
      end
    end
  end

  assign ready      = r_ready;
  assign dec_in     = r_dec;
  assign anode      = r_anode;
  assign digit_idx  = r_idx;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl
// A cycle model queues expected outputs per driven cycle; a monitor pops and compares them.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'd0;
  logic        ready;
  logic [3:0]  dec_in;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] sb_q[$];

  int          m_cnt  = 0;
  int          m_slot = 0;
  logic [15:0] m_act  = 16'd0;
  logic [15:0] m_sh   = 16'd0;
  bit          m_pend = 1'b0;

  display_scan_ctrl #(
    .REFRESH_DIV  (4),
    .ANODE_ACT_LOW(1'b1),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .digits_in (digits_in),
    .ready     (ready),
    .dec_in    (dec_in),
    .anode     (anode),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive inputs, advance the model, queue the post-edge outputs.
  task automatic step(input bit r, input bit e, input bit l, input logic [15:0] d);
    bit         wrap, ft, commit;
    int         top;
    logic [3:0] an, nib;
    logic [1:0] slot2;
    rst = r; en = e; load = l; digits_in = d;
    if (r) begin
      m_cnt = 0; m_slot = 0; m_act = 16'd0; m_sh = 16'd0; m_pend = 1'b0;
      sb_q.push_back({1'b1, 4'h0, 4'b1110, 2'd0, 1'b0});
    end else begin
      wrap   = e && (m_cnt == 3);
      ft     = wrap && (m_slot == 3);
      commit = ft && m_pend;
      if (e) m_cnt = (m_cnt + 1) % 4;
      if (wrap) m_slot = (m_slot + 1) % 4;
      if (l && !m_pend) begin
        m_sh = d; m_pend = 1'b1;
      end else if (commit) begin
        m_act = m_sh; m_pend = 1'b0;
      end
      top = 0;
      for (int k = 0; k < 4; k++) if (m_act[k*4 +: 4] != 4'd0) top = k;
      nib   = m_act[m_slot*4 +: 4];
      an    = (!e || m_slot > top) ? 4'b1111 : ~(4'b0001 << m_slot);
      slot2 = m_slot[1:0];
      sb_q.push_back({!m_pend, nib, an, slot2, ft});
    end
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  task automatic run_until_ft(input string tag);
    int n = 0;
    step(1'b0, 1'b1, 1'b0, 16'd0);
    while (!frame_tick && n < 64) begin
      step(1'b0, 1'b1, 1'b0, 16'd0);
      n++;
    end
    check({tag, "_frame_tick"}, 16'(frame_tick), 16'd1);
  endtask

  task automatic run_until_wrap(input string tag);
    int n = 0;
    while (!(m_slot == 3 && m_cnt == 3) && n < 64) begin
      step(1'b0, 1'b1, 1'b0, 16'd0);
      n++;
    end
    check({tag, "_wrap_reached"}, 16'(digit_idx), 16'd3);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        logic [11:0] exp_v;
        exp_v = sb_q.pop_front();
        check("outputs", {4'd0, ready, dec_in, anode, digit_idx, frame_tick}, {4'd0, exp_v});
      end
    end
  end

  initial begin
    logic [1:0] held_idx;
    @(negedge clk);

    // Reset and leading-zero blanking of an all-zero value
    step(1'b1, 1'b1, 1'b0, 16'd0);
    check("rst_anode", 16'(anode), 16'h000E);
    check("rst_ready", 16'(ready), 16'd1);
    run_n(4);
    check("zero_slot1_anode", 16'(anode), 16'h000F);
    check("zero_slot1_idx", 16'(digit_idx), 16'd1);

    // Load 1234 at cycle 2, commit at the boundary
    step(1'b1, 1'b1, 1'b0, 16'd0);
    run_n(1);
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    check("s2_ready_low", 16'(ready), 16'd0);
    run_until_ft("s2");
    check("s2_u_dec", 16'(dec_in), 16'd4);
    check("s2_u_anode", 16'(anode), 16'h000E);
    check("s2_ready_commit", 16'(ready), 16'd1);
    run_n(4);
    check("s2_t_dec", 16'(dec_in), 16'd3);
    check("s2_t_anode", 16'(anode), 16'h000D);
    run_n(4);
    check("s2_h_anode", 16'(anode), 16'h000B);
    run_n(4);
    check("s2_th_dec", 16'(dec_in), 16'd1);
    check("s2_th_anode", 16'(anode), 16'h0007);

    // Load while busy is ignored
    step(1'b0, 1'b1, 1'b1, 16'h0777);
    step(1'b0, 1'b1, 1'b1, 16'h9999);
    check("s4_ready_busy", 16'(ready), 16'd0);
    run_until_ft("s4");
    check("s4_u_dec", 16'(dec_in), 16'd7);
    check("s4_ready", 16'(ready), 16'd1);
    run_n(4);
    check("s4_t_dec", 16'(dec_in), 16'd7);

    // Load held across the boundary while pending: old commits, new one frame later
    step(1'b0, 1'b1, 1'b1, 16'h0011);
    run_until_wrap("s5");
    step(1'b0, 1'b1, 1'b1, 16'h0022);
    check("s5_wrap_ft", 16'(frame_tick), 16'd1);
    check("s5_old_dec", 16'(dec_in), 16'd1);
    step(1'b0, 1'b1, 1'b1, 16'h0022);
    check("s5_new_accepted", 16'(ready), 16'd0);
    run_until_ft("s5");
    check("s5_new_dec", 16'(dec_in), 16'd2);

    // Load with ready=1 exactly at the boundary commits one frame later
    run_until_wrap("s3");
    step(1'b0, 1'b1, 1'b1, 16'h0050);
    check("s3_no_commit_yet", 16'(dec_in), 16'd2);
    run_until_ft("s3");
    check("s3_u_dec", 16'(dec_in), 16'd0);
    check("s3_u_anode", 16'(anode), 16'h000E);
    run_n(4);
    check("s3_t_dec", 16'(dec_in), 16'd5);
    check("s3_t_anode", 16'(anode), 16'h000D);
    run_n(4);
    check("s3_h_anode", 16'(anode), 16'h000F);

    // Reset mid-frame with a pending value, then en low mid-slot
    step(1'b0, 1'b1, 1'b1, 16'h4321);
    run_n(3);
    step(1'b1, 1'b1, 1'b0, 16'd0);
    check("s6_rst_ready", 16'(ready), 16'd1);
    check("s6_rst_idx", 16'(digit_idx), 16'd0);
    run_until_ft("s6");
    check("s6_pending_lost", 16'(dec_in), 16'd0);
    run_n(6);
    held_idx = digit_idx;
    repeat (10) step(1'b0, 1'b0, 1'b0, 16'd0);
    check("s6_en_off_anode", 16'(anode), 16'h000F);
    check("s6_en_off_idx", 16'(digit_idx), 16'(held_idx));
    run_n(2);
    check("s6_resume_idx", 16'(digit_idx), 16'(held_idx + 2'd1));
    run_until_ft("s6_resume");

    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
